fall_event_monitor: RTL

- Downstream consumer of a sampled multi-bit bus (default 4 bits).
- Every rising clk edge it samples the bus and detects per-bit 1->0 transitions against the previous sample; bit 0 follows $fell semantics.
- Each non-empty fall set becomes a timestamped event record in a small FIFO, drained over a valid/ready interface.
- Maintains a saturating bit-0 fall counter and drop/overflow status, giving the bench a hardware-side check against $fell observations.

---
 rtl/fall_event_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fall_event_monitor.sv
// Samples a bus every edge, turns per-bit 1->0 transitions into timestamped
// records queued in a small FIFO, and keeps bit-0 fall / drop statistics.
module fall_event_monitor #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic [TS_W-1:0]  evt_ts,
    output logic [CNT_W-1:0] fell_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow,
    output logic [1:0]       state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [TS_W-1:0]  ts_q;
    logic             run;

    logic [WIDTH-1:0] mask_mem_q [DEPTH];
    logic [TS_W-1:0]  ts_mem_q   [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic [CNT_W-1:0] fell_cnt_q, drop_cnt_q;
    logic             overflow_q;

    logic [WIDTH-1:0] fall_mask;
    logic             push, pop, full, accept, drop;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = ARM;
            ARM:     state_d = en ? RUN : IDLE;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ARM and RUN both resample the bus so RUN never compares against a stale value
    always_comb begin
        run    = (state_q == RUN);
        prev_d = (state_q == IDLE) ? prev_q : b;
    end

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            ts_q   <= '0;
        end else begin
            prev_q <= prev_d;
            ts_q   <= ts_q + 1'b1;
        end
    end

    // ---------------- detection / FIFO control ----------------
    assign fall_mask = run ? (prev_q & ~b) : '0;
    assign push      = (|fall_mask) && !clr;
    assign pop       = evt_valid && evt_ready && !clr;
    assign full      = (cnt_q == FULL_CNT);
    assign accept    = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (accept) begin
            mask_mem_q[wr_ptr_q] <= fall_mask;
            ts_mem_q[wr_ptr_q]   <= ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // fell_cnt counts every bit-0 fall, even ones whose record gets dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fell_cnt_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            fell_cnt_q <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fall_mask[0] && (fell_cnt_q != '1)) fell_cnt_q <= fell_cnt_q + 1'b1;
            if (drop) begin
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
                overflow_q <= 1'b1;
            end
        end
    end

    assign evt_valid = (cnt_q != '0);
    assign evt_mask  = evt_valid ? mask_mem_q[rd_ptr_q] : '0;
    assign evt_ts    = evt_valid ? ts_mem_q[rd_ptr_q]   : '0;
    assign fell_cnt  = fell_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule
